// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared processor package for the memory arbiter slice.
// Provides:
//   - FSM state encodings for the arbiter (IDLE / BUSY_IF / BUSY_DM)
//   - load/store opcode constants used to tag the latched access
//   - sat_inc: saturating 3-bit increment used by the starvation counter
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_BUSY_IF = 2'b01;
    localparam logic [1:0] ST_BUSY_DM = 2'b10;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;

    function automatic logic [2:0] sat_inc(input logic [2:0] value,
                                           input logic [2:0] max_value);
        return (value >= max_value) ? max_value : value + 3'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick
// Priority decision between the fetch and data requesters.
// Data normally wins; once fetch has been passed over STARVE_MAX times in a
// row it is given the port instead.
// Ports:
//   if_req     in  fetch request
//   dm_req     in  data request
//   starve_cnt in  consecutive data grants made while fetch was waiting
//   pick_dm    out 1 = grant data requester, 0 = grant fetch requester
module arb_pick #(
    parameter int STARVE_MAX = 3
) (
    input  logic       if_req,
    input  logic       dm_req,
    input  logic [2:0] starve_cnt,
    output logic       pick_dm
);

    assign pick_dm = dm_req && !(if_req && (starve_cnt == 3'(STARVE_MAX)));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a single-ported memory between an instruction-fetch requester
// and a load/store requester. One access is outstanding at a time; the
// winner's address/opcode/data are latched at grant and the memory port is
// driven only from those latched copies.
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   if_req/if_addr            fetch request and address
//   if_done/if_rdata          fetch completion pulse and fetched word
//   dm_req/dm_we/dm_addr/
//   dm_wdata                  load/store request, store flag, address, data
//   dm_done/dm_rdata          load/store completion pulse and load data
//   mem_en_o/mem_we_o/
//   mem_addr_o/mem_wdata_o    memory strobe, write strobe, address, data
//   mem_rdata_i               memory read data, valid MEM_LAT clocks after strobe
//   busy_o                    high whenever an access is in flight
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    logic [1:0]        state_q, state_d;
    logic [2:0]        starve_q, starve_d;
    logic [2:0]        lat_q, lat_d;
    logic              en_q, en_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              pick_dm;

    arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb_pick (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .starve_cnt(starve_q),
        .pick_dm   (pick_dm)
    );

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        en_d       = 1'b0;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    en_d  = 1'b1;
                    lat_d = 3'(MEM_LAT);
                    if (pick_dm) begin
                        state_d = ST_BUSY_DM;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        op_d    = dm_we ? OP_STORE : OP_LOAD;
                        // Only count data grants that actually made fetch wait.
                        if (if_req) begin
                            starve_d = sat_inc(starve_q, 3'(STARVE_MAX));
                        end
                    end else begin
                        state_d  = ST_BUSY_IF;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        op_d     = OP_LOAD;
                        starve_d = 3'd0;
                    end
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                // lat_q == 1 marks the cycle where read data is valid; the
                // done pulse and captured data appear together one edge later.
                if (lat_q == 3'd1) begin
                    state_d = ST_IDLE;
                    lat_d   = 3'd0;
                    if (state_q == ST_BUSY_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end else begin
                        dm_done_d = 1'b1;
                        if (op_q != OP_STORE) begin
                            dm_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lat_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            starve_q   <= 3'd0;
            lat_q      <= 3'd0;
            en_q       <= 1'b0;
            op_q       <= OP_LOAD;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            en_q       <= en_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_en_o    = en_q;
    assign mem_we_o    = en_q && (state_q == ST_BUSY_DM) && (op_q == OP_STORE);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_done     = if_done_q;
    assign dm_done     = dm_done_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with default parameters (8-bit address and
// data, MEM_LAT = 2, STARVE_MAX = 3). A small memory model answers reads one
// clock after the strobe cycle, which is when the arbiter captures read data
// for MEM_LAT = 2, and returns 0 at all other times.
module tb_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_done;
    logic [7:0] if_rdata;
    logic       dm_req;
    logic       dm_we;
    logic [7:0] dm_addr;
    logic [7:0] dm_wdata;
    logic       dm_done;
    logic [7:0] dm_rdata;
    logic       mem_en_o;
    logic       mem_we_o;
    logic [7:0] mem_addr_o;
    logic [7:0] mem_wdata_o;
    logic [7:0] mem_rdata_i;
    logic       busy_o;

    int checkCount;
    int errorCount;

    logic       storeValid;
    logic [7:0] storeAddr;
    logic [7:0] storeData;
    logic [7:0] rdQ;

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W(8), .DATA_W(8), .MEM_LAT(2), .STARVE_MAX(3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_done    (dm_done),
        .dm_rdata   (dm_rdata),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .busy_o     (busy_o)
    );

    // Memory contents: address 0x10 holds 0xA5, the last stored location
    // holds its stored byte, everything else reads addr ^ 0x5A.
    function automatic logic [7:0] memRead(input logic [7:0] a);
        if (storeValid && a == storeAddr) return storeData;
        if (a == 8'h10) return 8'hA5;
        return a ^ 8'h5A;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            storeValid <= 1'b0;
        end else if (mem_en_o && mem_we_o) begin
            storeValid <= 1'b1;
            storeAddr  <= mem_addr_o;
            storeData  <= mem_wdata_o;
        end
        rdQ <= (mem_en_o && !mem_we_o) ? memRead(mem_addr_o) : 8'h00;
    end

    assign mem_rdata_i = rdQ;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic iReq, input logic [7:0] iAddr,
                                 input logic dReq, input logic dWe,
                                 input logic [7:0] dAddr, input logic [7:0] dData);
        if_req   = iReq;
        if_addr  = iAddr;
        dm_req   = dReq;
        dm_we    = dWe;
        dm_addr  = dAddr;
        dm_wdata = dData;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    initial begin
        int grants;
        int overlaps;
        logic grantIsDm [8];

        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        tick();

        // Reset state
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_en", mem_en_o, 1'b0);
        checkOutput("rst_we", mem_we_o, 1'b0);
        checkOutput("rst_if_done", if_done, 1'b0);
        checkOutput("rst_dm_done", dm_done, 1'b0);
        checkOutput("rst_if_rdata", if_rdata, 8'h00);
        checkOutput("rst_dm_rdata", dm_rdata, 8'h00);
        checkOutput("rst_addr", mem_addr_o, 8'h00);
        checkOutput("rst_wdata", mem_wdata_o, 8'h00);
        reset = 1'b0;

        // Lone fetch from 0x10
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("if_en", mem_en_o, 1'b1);
        checkOutput("if_we", mem_we_o, 1'b0);
        checkOutput("if_addr", mem_addr_o, 8'h10);
        checkOutput("if_busy", busy_o, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("if_en_off", mem_en_o, 1'b0);
        checkOutput("if_done_early", if_done, 1'b0);
        tick();
        checkOutput("if_done", if_done, 1'b1);
        checkOutput("if_rdata", if_rdata, 8'hA5);
        checkOutput("if_dm_done", dm_done, 1'b0);
        checkOutput("if_idle", busy_o, 1'b0);
        tick();
        checkOutput("if_done_pulse", if_done, 1'b0);
        checkOutput("if_rdata_hold", if_rdata, 8'hA5);

        // Store 0x3C to 0x20
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C);
        tick();
        checkOutput("st_en", mem_en_o, 1'b1);
        checkOutput("st_we", mem_we_o, 1'b1);
        checkOutput("st_addr", mem_addr_o, 8'h20);
        checkOutput("st_wdata", mem_wdata_o, 8'h3C);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("st_en_off", mem_en_o, 1'b0);
        checkOutput("st_we_off", mem_we_o, 1'b0);
        tick();
        checkOutput("st_done", dm_done, 1'b1);
        checkOutput("st_rdata_kept", dm_rdata, 8'h00);
        checkOutput("st_if_done", if_done, 1'b0);
        tick();
        checkOutput("st_done_pulse", dm_done, 1'b0);

        // Load back from 0x20
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        checkOutput("ld_en", mem_en_o, 1'b1);
        checkOutput("ld_we", mem_we_o, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("ld_done", dm_done, 1'b1);
        checkOutput("ld_rdata", dm_rdata, 8'h3C);

        // Both request, data drops one cycle after grant, fetch follows
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        checkOutput("drop_dm_first", mem_addr_o, 8'h20);
        checkOutput("drop_en", mem_en_o, 1'b1);
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h20, 8'h00);
        tick();
        tick();
        checkOutput("drop_dm_done", dm_done, 1'b1);
        checkOutput("drop_if_done0", if_done, 1'b0);
        tick();
        checkOutput("drop_if_en", mem_en_o, 1'b1);
        checkOutput("drop_if_addr", mem_addr_o, 8'h10);
        checkOutput("drop_dm_once", dm_done, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("drop_if_done", if_done, 1'b1);
        checkOutput("drop_if_rdata", if_rdata, 8'hA5);
        tick();

        // Reset in the second BUSY_DM cycle
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        tick();
        checkOutput("mid_busy", busy_o, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("mid_no_done", dm_done, 1'b0);
        checkOutput("mid_busy_off", busy_o, 1'b0);
        checkOutput("mid_en", mem_en_o, 1'b0);
        checkOutput("mid_addr", mem_addr_o, 8'h00);
        checkOutput("mid_dm_rdata", dm_rdata, 8'h00);
        checkOutput("mid_if_rdata", if_rdata, 8'h00);
        reset = 1'b0;
        tick();
        checkOutput("mid_if_en", mem_en_o, 1'b1);
        checkOutput("mid_if_addr", mem_addr_o, 8'h10);
        checkOutput("mid_dm_done_after", dm_done, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("mid_if_done", if_done, 1'b1);
        tick();

        // Continuous contention: expect DM,DM,DM,IF repeating
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00);
        grants   = 0;
        overlaps = 0;
        for (int c = 0; c < 60 && grants < 8; c++) begin
            tick();
            if (if_done && dm_done) overlaps++;
            if (mem_en_o) begin
                grantIsDm[grants] = (mem_addr_o == 8'h20);
                grants++;
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("cont_grants", grants, 8);
        for (int g = 0; g < grants; g++) begin
            checkOutput($sformatf("cont_order%0d", g), grantIsDm[g], (g % 4) != 3);
        end
        checkOutput("cont_overlap", overlaps, 0);
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
